// File: rtl/cnn_inference_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_inference_sequencer_pkg
// Brief    : Shared constants for the CNN layer sequencer: state encodings,
//            stage indices and default parameter values.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_inference_sequencer_pkg;

  // Default parameter values for the sequencer and its watchdog
  localparam int NUM_STAGES_DEF = 5;
  localparam int STAGE_W_DEF    = 3;
  localparam int TIMEOUT_W_DEF  = 16;
  localparam int LABEL_W_DEF    = 4;

  // Sequencer state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_LAUNCH = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
  localparam logic [2:0] ST_ABORT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CLEAR  = ST_CLEAR,
    S_LAUNCH = ST_LAUNCH,
    S_WAIT   = ST_WAIT,
    S_FINISH = ST_FINISH,
    S_ABORT  = ST_ABORT
  } seq_state_t;

  // Layer scheduler indices in execution order; the last one is the label predictor
  localparam logic [2:0] STG_CONV1 = 3'd0;
  localparam logic [2:0] STG_POOL1 = 3'd1;
  localparam logic [2:0] STG_CONV2 = 3'd2;
  localparam logic [2:0] STG_FC    = 3'd3;
  localparam logic [2:0] STG_PRED  = 3'd4;

endpackage : cnn_inference_sequencer_pkg
`default_nettype wire

// File: rtl/cnn_inference_sequencer_stage_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : cnn_inference_sequencer_stage_watchdog
// Brief    : Saturating per-stage watchdog. Cleared when a stage is launched,
//            counts while enabled, flags expiry once the count is all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_inference_sequencer_stage_watchdog
  import cnn_inference_sequencer_pkg::*;
#(
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  logic [TIMEOUT_W-1:0] r_count;
  logic                 w_sat;

  // All-ones is both the expiry point and the saturation point, so it never wraps
  assign w_sat     = &r_count;
  assign o_expired = w_sat;

  // Counter: clear has priority over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en && !w_sat) begin
      r_count <= r_count + TIMEOUT_W'(1);
    end
  end

endmodule : cnn_inference_sequencer_stage_watchdog
`default_nettype wire

// File: rtl/cnn_inference_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cnn_inference_sequencer
// Brief    : Top-level layer sequencer for the MNIST CNN accelerator. Runs the
//            layer schedulers in order over start/done handshakes, steers the
//            shared picture memory port, latches the predicted label and
//            reports done/error to the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_inference_sequencer
  import cnn_inference_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int STAGE_W    = STAGE_W_DEF,
  parameter int TIMEOUT_W  = TIMEOUT_W_DEF,
  parameter int LABEL_W    = LABEL_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  timeout_en,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  stage_rst_n,
  output logic [STAGE_W-1:0]    mem_sel,
  input  logic [LABEL_W-1:0]    label_in,
  output logic [LABEL_W-1:0]    result_label,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [STAGE_W-1:0]    err_stage
);

  localparam logic [STAGE_W-1:0] LAST_IDX = STAGE_W'(NUM_STAGES - 1);

  seq_state_t            r_state;
  seq_state_t            w_next_state;
  logic [STAGE_W-1:0]    r_stage_idx;
  logic [STAGE_W-1:0]    w_next_idx;
  logic [NUM_STAGES-1:0] w_idx_onehot;
  logic                  w_cur_done;
  logic                  w_wd_expired;
  logic                  w_wd_clear;
  logic                  w_wd_count_en;
  logic [LABEL_W-1:0]    r_result_label;
  logic                  r_err;
  logic [STAGE_W-1:0]    r_err_stage;

  // One-hot decode of the active stage; also masks off done bits of other stages
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_idx_decode
      assign w_idx_onehot[gi] = (r_stage_idx == STAGE_W'(gi));
    end
  endgenerate

  assign w_cur_done    = |(stage_done & w_idx_onehot);
  assign w_wd_clear    = (r_state == S_LAUNCH);
  assign w_wd_count_en = (r_state == S_WAIT) && timeout_en;

  cnn_inference_sequencer_stage_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_stage_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_wd_clear),
    .i_count_en (w_wd_count_en),
    .o_expired  (w_wd_expired)
  );

  // State and stage-index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_stage_idx <= '0;
    end else begin
      r_state     <= w_next_state;
      r_stage_idx <= w_next_idx;
    end
  end

  // Next-state logic; in WAIT abort beats done, done beats timeout
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_stage_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_CLEAR;
          w_next_idx   = '0;
        end
      end
      S_CLEAR:  w_next_state = abort ? S_ABORT : S_LAUNCH;
      S_LAUNCH: w_next_state = abort ? S_ABORT : S_WAIT;
      S_WAIT: begin
        if (abort) begin
          w_next_state = S_ABORT;
        end else if (w_cur_done) begin
          if (r_stage_idx == LAST_IDX) begin
            w_next_state = S_FINISH;
          end else begin
            w_next_state = S_LAUNCH;
            w_next_idx   = r_stage_idx + STAGE_W'(1);
          end
        end else if (timeout_en && w_wd_expired) begin
          w_next_state = S_ABORT;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      S_ABORT:  w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state/index
  always_comb begin
    stage_start = '0;
    stage_rst_n = 1'b1;
    mem_sel     = r_stage_idx;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy    = 1'b0;
        mem_sel = '0;
      end
      S_CLEAR:  stage_rst_n = 1'b0;
      S_LAUNCH: stage_start = w_idx_onehot;
      S_FINISH: done = 1'b1;
      S_ABORT: begin
        done        = 1'b1;
        stage_rst_n = 1'b0;
        mem_sel     = '0;
      end
      default: ;
    endcase
  end

  // Result label on the final done edge; sticky error cleared by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_label <= '0;
      r_err          <= 1'b0;
      r_err_stage    <= '0;
    end else begin
      if (r_state == S_WAIT && w_next_state == S_FINISH) begin
        r_result_label <= label_in;
      end
      if (r_state == S_IDLE && start) begin
        r_err <= 1'b0;
      end
      if (r_state == S_ABORT) begin
        r_err       <= 1'b1;
        r_err_stage <= r_stage_idx;
      end
    end
  end

  assign result_label = r_result_label;
  assign err          = r_err;
  assign err_stage    = r_err_stage;

endmodule : cnn_inference_sequencer
`default_nettype wire

// File: tb/tb_cnn_inference_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_inference_sequencer
// Brief    : Directed self-checking bench for the CNN layer sequencer.
//            Cycle numbers below count the cycle in which start is driven as 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_inference_sequencer;

  localparam int NS = 5;
  localparam int SW = 3;
  localparam int TW = 4;
  localparam int LW = 4;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          start      = 1'b0;
  logic          abort      = 1'b0;
  logic          timeout_en = 1'b0;
  logic [NS-1:0] stage_done = '0;
  logic [LW-1:0] label_in   = '0;
  logic [NS-1:0] stage_start;
  logic          stage_rst_n;
  logic [SW-1:0] mem_sel;
  logic [LW-1:0] result_label;
  logic          busy;
  logic          done;
  logic          err;
  logic [SW-1:0] err_stage;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder settings: lat[i] = cycles from stage_start[i] to stage_done[i], 0 = never
  int lat [NS];
  int abort_stg = -1;
  bit spur_en   = 1'b0;
  int rst_stg   = -1;

  // Observations of one run
  int t_done_cyc, t_done_cnt, t_busy_drop, t_clr_low, t_stg_seen, t_order_err, t_err_c1, t_rst_hit;

  cnn_inference_sequencer #(
    .NUM_STAGES (NS),
    .STAGE_W    (SW),
    .TIMEOUT_W  (TW),
    .LABEL_W    (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .timeout_en   (timeout_en),
    .stage_start  (stage_start),
    .stage_done   (stage_done),
    .stage_rst_n  (stage_rst_n),
    .mem_sel      (mem_sel),
    .label_in     (label_in),
    .result_label (result_label),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_stage    (err_stage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_stage_start"}, 32'(stage_start), 32'd0);
    chk({p, "_stage_rst_n"}, 32'(stage_rst_n), 32'd1);
    chk({p, "_mem_sel"}, 32'(mem_sel), 32'd0);
    chk({p, "_busy"}, 32'(busy), 32'd0);
    chk({p, "_done"}, 32'(done), 32'd0);
    chk({p, "_err"}, 32'(err), 32'd0);
    chk({p, "_err_stage"}, 32'(err_stage), 32'd0);
    chk({p, "_result_label"}, 32'(result_label), 32'd0);
  endtask

  // Drive start at a falling edge, then act as the stage schedulers each falling
  // edge until the cycle after done (or until rst_n is dropped / budget runs out).
  task automatic run_job(input int budget);
    int cnt;
    int cur;
    cnt = 0; cur = 0;
    t_done_cyc = -1; t_done_cnt = 0; t_busy_drop = 0; t_clr_low = 0;
    t_stg_seen = 0; t_order_err = 0; t_err_c1 = -1; t_rst_hit = 0;
    start = 1'b1;
    for (int ncyc = 1; ncyc <= budget; ncyc++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; stage_done = '0;
      if (ncyc == 1) t_err_c1 = int'(err);
      if (done) begin
        t_done_cnt++;
        if (t_done_cyc < 0) t_done_cyc = ncyc;
      end else if (t_done_cnt > 0) begin
        break;
      end
      if (!stage_rst_n) t_clr_low++;
      if (!busy) t_busy_drop++;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          stage_done = NS'(1 << cur);
          if (cur == abort_stg) abort = 1'b1;
        end
      end
      if (spur_en && cur == 1 && cnt == 5) begin
        stage_done = NS'(1 << 3);
        start      = 1'b1;
      end
      if (stage_start != '0) begin
        if (t_stg_seen >= NS || stage_start != NS'(1 << t_stg_seen) || mem_sel != SW'(t_stg_seen))
          t_order_err++;
        if (t_stg_seen < NS) begin
          cur = t_stg_seen;
          cnt = lat[cur];
        end
        t_stg_seen++;
      end
      if (cur == rst_stg && t_stg_seen == rst_stg + 1 && cnt == lat[cur] - 3) begin
        rst_n = 1'b0;
        t_rst_hit = 1;
        #1;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; stage_done = '0;
  endtask

  initial begin
    // Reset values while rst_n is held low
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Done pulses in IDLE are ignored
    stage_done = '1;
    @(negedge clk);
    stage_done = '0;
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_done", 32'(done), 32'd0);

    // Nominal: each stage 10 cycles; LAUNCH_k at 2+11k, last done at 56, FINISH at 57
    lat = '{10, 10, 10, 10, 10};
    label_in = 4'd7; timeout_en = 1'b1;
    run_job(200);
    chk("nom_done_cyc", t_done_cyc, 57);
    chk("nom_done_cnt", t_done_cnt, 1);
    chk("nom_stages", t_stg_seen, 5);
    chk("nom_order", t_order_err, 0);
    chk("nom_busy", t_busy_drop, 0);
    chk("nom_clr_low", t_clr_low, 1);
    chk("nom_label", 32'(result_label), 32'd7);
    chk("nom_err", 32'(err), 32'd0);
    chk("nom_idle_busy", 32'(busy), 32'd0);

    // Zero-length stages: start->done = 2*5+2 = 12 cycles
    lat = '{1, 1, 1, 1, 1};
    label_in = 4'd9;
    run_job(100);
    chk("zero_done_cyc", t_done_cyc, 12);
    chk("zero_order", t_order_err, 0);
    chk("zero_label", 32'(result_label), 32'd9);

    // Timeout on stage 2 (TIMEOUT_W=4): WAIT2 from cycle 7 with watchdog 0, reaches 15
    // in cycle 22 after 15 counted cycles, ABORT in cycle 23
    lat = '{1, 1, 0, 1, 1};
    label_in = 4'd2;
    run_job(100);
    chk("tmo_done_cyc", t_done_cyc, 23);
    chk("tmo_done_cnt", t_done_cnt, 1);
    chk("tmo_stages", t_stg_seen, 3);
    chk("tmo_clr_low", t_clr_low, 2);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_err_stage", 32'(err_stage), 32'd2);
    chk("tmo_label", 32'(result_label), 32'd9);
    chk("tmo_mem_sel_idle", 32'(mem_sel), 32'd0);

    // Abort and done together in stage 4 WAIT: LAUNCH4 at 18, both at 21, ABORT at 22
    lat = '{3, 3, 3, 3, 3};
    abort_stg = 4; timeout_en = 1'b0;
    label_in = 4'd4;
    run_job(100);
    abort_stg = -1;
    chk("abt_err_cleared", t_err_c1, 0);
    chk("abt_done_cyc", t_done_cyc, 22);
    chk("abt_stages", t_stg_seen, 5);
    chk("abt_clr_low", t_clr_low, 2);
    chk("abt_err", 32'(err), 32'd1);
    chk("abt_err_stage", 32'(err_stage), 32'd4);
    chk("abt_label", 32'(result_label), 32'd9);

    // Spurious stage_done[3] and start while stage 1 is active: run is unchanged
    lat = '{10, 10, 10, 10, 10};
    spur_en = 1'b1;
    label_in = 4'd7;
    run_job(200);
    spur_en = 1'b0;
    chk("spur_done_cyc", t_done_cyc, 57);
    chk("spur_done_cnt", t_done_cnt, 1);
    chk("spur_order", t_order_err, 0);
    chk("spur_label", 32'(result_label), 32'd7);
    chk("spur_err", 32'(err), 32'd0);

    // Async reset during stage 3 WAIT returns everything to reset values at once
    rst_stg = 3;
    run_job(200);
    rst_stg = -1;
    chk("ares_hit", t_rst_hit, 1);
    chk_reset("ares");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // New run after the reset starts again from stage 0
    lat = '{1, 1, 1, 1, 1};
    label_in = 4'd6;
    run_job(100);
    chk("post_done_cyc", t_done_cyc, 12);
    chk("post_order", t_order_err, 0);
    chk("post_label", 32'(result_label), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cnn_inference_sequencer
`default_nettype wire
